cdb_arbiter: RTL

//  Shares the single common data bus (CDB) between N functional-unit result

---
 rtl/cdb_arbiter.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/cdb_arbiter.sv
// -----------------------------------------------------------------------------
// cdb_arbiter
// Shares the single common data bus (CDB) between NUM_FU functional-unit result
// ports. Each cycle at most one valid requester is granted (round-robin from
// rr_ptr), and the winner's result is registered onto the CDB one cycle later.
//
// Optional feature macro: CDB_ARB_FIXED_PRIO_EN
//   defined   -> requester 0 (LSU) wins whenever fu_valid[0]=1, without moving
//                rr_ptr; the other requesters share round-robin.
//   undefined -> pure round-robin over all NUM_FU requesters.
//
// Ports
//   clk          in   clock, all state on rising edge
//   rst          in   asynchronous active-low reset
//   flush        in   synchronous pipeline squash, active-high
//   fu_valid     in   [NUM_FU]            requester i holds a completed result
//   fu_data      in   [NUM_FU*DATA_W]     result data, slice i
//   fu_rd_addr   in   [NUM_FU*RD_W]       destination arch register, slice i
//   fu_rob_idx   in   [NUM_FU*ROB_IDX_W]  ROB tag, slice i
//   fu_ready     out  [NUM_FU]            onehot0 grant, combinational
//   cdb_valid    out  registered broadcast valid
//   cdb_data     out  registered broadcast data
//   cdb_rd_addr  out  registered broadcast destination register
//   cdb_rob_idx  out  registered broadcast ROB tag
//   cdb_src      out  registered index of the winning requester
// -----------------------------------------------------------------------------
module cdb_arbiter #(
    parameter int NUM_FU    = 4,
    parameter int DATA_W    = 32,
    parameter int RD_W      = 5,
    parameter int ROB_IDX_W = 5,
    localparam int SRC_W    = (NUM_FU > 1) ? $clog2(NUM_FU) : 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          flush,
    input  logic [NUM_FU-1:0]             fu_valid,
    input  logic [NUM_FU*DATA_W-1:0]      fu_data,
    input  logic [NUM_FU*RD_W-1:0]        fu_rd_addr,
    input  logic [NUM_FU*ROB_IDX_W-1:0]   fu_rob_idx,
    output logic [NUM_FU-1:0]             fu_ready,
    output logic                          cdb_valid,
    output logic [DATA_W-1:0]             cdb_data,
    output logic [RD_W-1:0]               cdb_rd_addr,
    output logic [ROB_IDX_W-1:0]          cdb_rob_idx,
    output logic [SRC_W-1:0]              cdb_src
);

    // (base + off) modulo NUM_FU; both operands are below NUM_FU, so a single
    // conditional subtraction is enough and non-power-of-two NUM_FU works.
    function automatic logic [SRC_W-1:0] wrap_add(
        input logic [SRC_W-1:0] base,
        input logic [SRC_W-1:0] off
    );
        logic [SRC_W:0] sum;
        sum = {1'b0, base} + {1'b0, off};
        if (sum >= (SRC_W+1)'(NUM_FU)) begin
            sum = sum - (SRC_W+1)'(NUM_FU);
        end else begin
            sum = sum;
        end
        return sum[SRC_W-1:0];
    endfunction

    logic [SRC_W-1:0]     rr_ptr_r;
    logic                 rr_found_s;
    logic [SRC_W-1:0]     rr_idx_s;
    logic                 prio_hit_s;
    logic                 grant_found_s;
    logic [SRC_W-1:0]     grant_idx_s;
    logic                 grant_any_s;
    logic [NUM_FU-1:0]    fu_ready_s;

    logic                 cdb_valid_r;
    logic [DATA_W-1:0]    cdb_data_r;
    logic [RD_W-1:0]      cdb_rd_addr_r;
    logic [ROB_IDX_W-1:0] cdb_rob_idx_r;
    logic [SRC_W-1:0]     cdb_src_r;

`ifdef CDB_ARB_FIXED_PRIO_EN
    // LSU on port 0 pre-empts the round-robin search whenever it is valid.
    assign prio_hit_s = fu_valid[0];
`else
    assign prio_hit_s = 1'b0;
`endif

    // Round-robin search: first valid requester at or after rr_ptr, wrapping.
    always_comb begin
        rr_found_s = 1'b0;
        rr_idx_s   = '0;
        for (int k = 0; k < NUM_FU; k++) begin
            if (!rr_found_s && fu_valid[wrap_add(rr_ptr_r, SRC_W'(k))]) begin
                rr_found_s = 1'b1;
                rr_idx_s   = wrap_add(rr_ptr_r, SRC_W'(k));
            end else begin
                rr_found_s = rr_found_s;
                rr_idx_s   = rr_idx_s;
            end
        end
    end

    // Final winner selection; flush and reset suppress any grant.
    always_comb begin
        grant_found_s = prio_hit_s | rr_found_s;
        if (prio_hit_s) begin
            grant_idx_s = '0;
        end else begin
            grant_idx_s = rr_idx_s;
        end
        grant_any_s = grant_found_s & ~flush & rst;
    end

    // Onehot0 grant vector decoded from the winner index.
    always_comb begin
        fu_ready_s = '0;
        for (int i = 0; i < NUM_FU; i++) begin
            fu_ready_s[i] = grant_any_s && (grant_idx_s == SRC_W'(i));
        end
    end

    assign fu_ready = fu_ready_s;

    // Round-robin pointer: moves past the winner, cleared by flush. Fixed-priority
    // grants to port 0 leave it where it is so the others keep their turn.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr_r <= '0;
        end else if (flush) begin
            rr_ptr_r <= '0;
        end else if (grant_any_s && !prio_hit_s) begin
            rr_ptr_r <= wrap_add(grant_idx_s, SRC_W'(1));
        end else begin
            rr_ptr_r <= rr_ptr_r;
        end
    end

    // CDB valid: high for exactly the cycle after a grant.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cdb_valid_r <= 1'b0;
        end else begin
            cdb_valid_r <= grant_any_s;
        end
    end

    // CDB payload: captured only on a grant, otherwise holds its last value.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cdb_data_r    <= '0;
            cdb_rd_addr_r <= '0;
            cdb_rob_idx_r <= '0;
            cdb_src_r     <= '0;
        end else if (grant_any_s) begin
            cdb_data_r    <= fu_data[grant_idx_s*DATA_W +: DATA_W];
            cdb_rd_addr_r <= fu_rd_addr[grant_idx_s*RD_W +: RD_W];
            cdb_rob_idx_r <= fu_rob_idx[grant_idx_s*ROB_IDX_W +: ROB_IDX_W];
            cdb_src_r     <= grant_idx_s;
        end else begin
            cdb_data_r    <= cdb_data_r;
            cdb_rd_addr_r <= cdb_rd_addr_r;
            cdb_rob_idx_r <= cdb_rob_idx_r;
            cdb_src_r     <= cdb_src_r;
        end
    end

    assign cdb_valid   = cdb_valid_r;
    assign cdb_data    = cdb_data_r;
    assign cdb_rd_addr = cdb_rd_addr_r;
    assign cdb_rob_idx = cdb_rob_idx_r;
    assign cdb_src     = cdb_src_r;

`ifndef SYNTHESIS
    cdb_arbiter_chk #(
        .NUM_FU (NUM_FU)
    ) u_chk (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .fu_valid (fu_valid),
        .fu_ready (fu_ready)
    );
`endif

endmodule

// -----------------------------------------------------------------------------
// cdb_arbiter_chk
// Simulation-only protocol checker for the arbiter grant vector.
//   clk, rst, flush, fu_valid, fu_ready : observed copies of the arbiter ports
// -----------------------------------------------------------------------------
module cdb_arbiter_chk #(
    parameter int NUM_FU = 4
) (
    input logic              clk,
    input logic              rst,
    input logic              flush,
    input logic [NUM_FU-1:0] fu_valid,
    input logic [NUM_FU-1:0] fu_ready
);

    a_ready_onehot0: assert property (@(posedge clk) disable iff (!rst)
        $onehot0(fu_ready));

    a_ready_implies_valid: assert property (@(posedge clk) disable iff (!rst)
        ((fu_ready & ~fu_valid) == '0));

    a_flush_no_grant: assert property (@(posedge clk) disable iff (!rst)
        flush |-> (fu_ready == '0));

endmodule
